// File: rtl/rvv_alu_seq.sv
// Sequencer driving NLANES rvv_alu lanes through one vector op: steps element
// groups and intra-element chunks, merges lane results into a VLEN image.
module rvv_alu_seq #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NLANES     = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [5:0]           req_opcode,
  input  logic                 req_mask,
  input  logic [2:0]           req_op_type,
  input  logic [2:0]           req_vsew,
  input  logic [16:0]          req_vl,
  input  logic [VLEN-1:0]      req_vd_old,
  output logic                 alu_run,
  output logic [5:0]           alu_opcode,
  output logic                 alu_instr_mask,
  output logic [2:0]           alu_op_type,
  output logic [2:0]           alu_vsew,
  output logic [16:0]          alu_byte_i,
  output logic [3:0]           alu_in_reg_offset,
  input  logic [NLANES*64-1:0] lane_vd,
  input  logic [NLANES*17-1:0] lane_index,
  input  logic [NLANES-1:0]    lane_instr_valid,
  output logic [VLEN-1:0]      vd_out,
  output logic                 vd_valid,
  output logic                 err_illegal,
  output logic                 busy
);

  localparam int LW = 32'sd1 << LANE_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [16:0]     vl_eff_r;
  logic [16:0]     vl_max_s;
  logic [16:0]     vl_eff_s;
  logic [3:0]      off_last_s;
  logic [63:0]     wmask_s;
  logic            last_s;
  logic            illegal_s;
  logic            err_nxt_s;
  logic            bad_req_s;
  logic [VLEN-1:0] vd_nxt_s;
  logic            unused_ok_s;

  // Only lane 0 is consulted for opcode legality; every lane sees the same opcode.
  assign unused_ok_s = ^lane_instr_valid;

  assign vl_max_s  = 17'(VLEN >> (32'(req_vsew) + 32'd3));
  assign vl_eff_s  = (req_vl < vl_max_s) ? req_vl : vl_max_s;
  assign bad_req_s = (req_vsew > 3'd3) || (vl_eff_s == 17'd0);
  assign last_s    = (alu_in_reg_offset == off_last_s) &&
                     ((18'(alu_byte_i) + 18'(NLANES)) >= 18'(vl_eff_r));
  assign illegal_s = (state_r == S_RUN) && (alu_byte_i == 17'd0) &&
                     (alu_in_reg_offset == 4'd0) && !lane_instr_valid[0];

  // Chunk count and per-lane write width derived from the latched SEW.
  always_comb begin
    int sew_lg;
    int sew_bits;
    int w_bits;
    sew_lg   = 32'(alu_vsew) + 32'sd3;
    sew_bits = 32'sd1 << sew_lg;
    w_bits   = (sew_bits < LW) ? sew_bits : LW;
    off_last_s = (sew_lg <= LANE_WIDTH) ? 4'd0
                 : 4'((32'sd1 << (sew_lg - LANE_WIDTH)) - 32'sd1);
    wmask_s = (w_bits >= 32'sd64) ? {64{1'b1}} : ((64'd1 << w_bits) - 64'd1);
  end

  // Merge every in-range lane chunk into the destination image; tail lanes are masked off.
  always_comb begin
    vd_nxt_s = vd_out;
    for (int i = 0; i < NLANES; i++) begin
      logic            we;
      logic [VLEN-1:0] msk;
      logic [VLEN-1:0] dat;
      we  = (18'(alu_byte_i) + 18'(i)) < 18'(vl_eff_r);
      msk = we ? (VLEN'(wmask_s) << lane_index[17*i +: 17]) : {VLEN{1'b0}};
      dat = VLEN'(lane_vd[64*i +: 64] & wmask_s) << lane_index[17*i +: 17];
      vd_nxt_s = (vd_nxt_s & ~msk) | (dat & msk);
    end
  end

  // Next-state and completion-error decode.
  always_comb begin
    state_nxt_s = state_r;
    err_nxt_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt_s = bad_req_s ? S_DONE : S_RUN;
          err_nxt_s   = (req_vsew > 3'd3);
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (illegal_s || last_s) begin
          state_nxt_s = S_DONE;
          err_nxt_s   = illegal_s;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      alu_run     <= 1'b0;
      vd_valid    <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      req_ready   <= (state_nxt_s == S_IDLE);
      busy        <= (state_nxt_s != S_IDLE);
      alu_run     <= (state_nxt_s == S_RUN);
      vd_valid    <= (state_nxt_s == S_DONE);
      err_illegal <= err_nxt_s;
    end
  end

  // Op field latch, group/chunk counters and destination image.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      alu_opcode        <= 6'd0;
      alu_instr_mask    <= 1'b0;
      alu_op_type       <= 3'd0;
      alu_vsew          <= 3'd0;
      alu_byte_i        <= 17'd0;
      alu_in_reg_offset <= 4'd0;
      vl_eff_r          <= 17'd0;
      vd_out            <= {VLEN{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            alu_opcode        <= req_opcode;
            alu_instr_mask    <= req_mask;
            alu_op_type       <= req_op_type;
            alu_vsew          <= req_vsew;
            alu_byte_i        <= 17'd0;
            alu_in_reg_offset <= 4'd0;
            vl_eff_r          <= vl_eff_s;
            vd_out            <= req_vd_old;
          end
        end
        S_RUN: begin
          if (!illegal_s) begin
            vd_out <= vd_nxt_s;
          end
          // Offset wraps at each element boundary so the ALUs can clear per-element state.
          if (alu_in_reg_offset == off_last_s) begin
            alu_in_reg_offset <= 4'd0;
            alu_byte_i        <= alu_byte_i + 17'(NLANES);
          end else begin
            alu_in_reg_offset <= alu_in_reg_offset + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvv_alu_seq.sv
// Directed bench for rvv_alu_seq with a behavioural model of four 8-bit lanes.
module tb_rvv_alu_seq;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_AND = 6'b001001;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [5:0]   req_opcode = 6'd0;
  logic         req_mask = 1'b0;
  logic [2:0]   req_op_type = 3'b001;
  logic [2:0]   req_vsew = 3'd0;
  logic [16:0]  req_vl = 17'd0;
  logic [127:0] req_vd_old = 128'd0;
  logic         alu_run;
  logic [5:0]   alu_opcode;
  logic         alu_instr_mask;
  logic [2:0]   alu_op_type;
  logic [2:0]   alu_vsew;
  logic [16:0]  alu_byte_i;
  logic [3:0]   alu_in_reg_offset;
  logic [255:0] lane_vd;
  logic [67:0]  lane_index;
  logic [3:0]   lane_instr_valid;
  logic [127:0] vd_out;
  logic         vd_valid;
  logic         err_illegal;
  logic         busy;

  logic [127:0] vs1 = 128'd0;
  logic [127:0] vs2 = 128'd0;

  int n_cmp  = 0;
  int n_fail = 0;

  rvv_alu_seq #(.VLEN(128), .LANE_WIDTH(3), .NLANES(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_mask(req_mask), .req_op_type(req_op_type),
    .req_vsew(req_vsew), .req_vl(req_vl), .req_vd_old(req_vd_old),
    .alu_run(alu_run), .alu_opcode(alu_opcode), .alu_instr_mask(alu_instr_mask),
    .alu_op_type(alu_op_type), .alu_vsew(alu_vsew), .alu_byte_i(alu_byte_i),
    .alu_in_reg_offset(alu_in_reg_offset),
    .lane_vd(lane_vd), .lane_index(lane_index), .lane_instr_valid(lane_instr_valid),
    .vd_out(vd_out), .vd_valid(vd_valid), .err_illegal(err_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sew_mask(input int sew);
    if (sew >= 64) return {64{1'b1}};
    else return (64'd1 << sew) - 64'd1;
  endfunction

  function automatic logic [63:0] elem(input logic [127:0] v, input int e, input int sew);
    logic [127:0] t;
    t = v >> (e * sew);
    return t[63:0] & sew_mask(sew);
  endfunction

  // One lane: full-element result, then the 8-bit chunk selected by the offset.
  function automatic logic [63:0] lane_res(input logic [127:0] v1, input logic [127:0] v2,
                                           input logic [16:0] bi, input logic [3:0] off,
                                           input logic [2:0] vsew, input logic [5:0] opc,
                                           input int i);
    int e;
    int sew;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    e   = int'(bi) + i;
    sew = 32'sd8 << vsew;
    a   = elem(v2, e, sew);
    b   = elem(v1, e, sew);
    case (opc)
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      default: r = 64'd0;
    endcase
    r = r & sew_mask(sew);
    return r >> (int'(off) * 8);
  endfunction

  function automatic logic [16:0] lane_idx(input logic [16:0] bi, input logic [3:0] off,
                                           input logic [2:0] vsew, input int i);
    return 17'((int'(bi) + i) * (32'sd8 << vsew) + int'(off) * 8);
  endfunction

  always_comb begin
    lane_vd          = '0;
    lane_index       = '0;
    lane_instr_valid = '0;
    for (int i = 0; i < 4; i++) begin
      lane_vd[64*i +: 64]   = lane_res(vs1, vs2, alu_byte_i, alu_in_reg_offset, alu_vsew, alu_opcode, i);
      lane_index[17*i +: 17] = lane_idx(alu_byte_i, alu_in_reg_offset, alu_vsew, i);
      lane_instr_valid[i]   = (alu_opcode == OP_ADD) || (alu_opcode == OP_AND);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, then watch until vd_valid (bounded); report timing and results.
  task automatic run_op(input logic [5:0] opc, input logic [2:0] vsew, input logic [16:0] vl,
                        input logic [127:0] old, input bit hold,
                        output int cyc, output int runs, output logic [15:0] offlog,
                        output logic [127:0] vd, output logic err, output int bad,
                        output logic vv_after, output logic [127:0] vd_after);
    cyc = 0; runs = 0; offlog = 16'd0; vd = 128'd0; err = 1'b0; bad = 0;
    req_opcode = opc; req_vsew = vsew; req_vl = vl; req_vd_old = old;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (req_ready || !busy) bad++;
      if (alu_run) begin
        runs++;
        offlog = {offlog[11:0], alu_in_reg_offset};
      end
      if (vd_valid) begin
        cyc = k;
        vd  = vd_out;
        err = err_illegal;
        req_valid = 1'b0;
        break;
      end
    end
    @(negedge clk);
    vv_after = vd_valid;
    vd_after = vd_out;
  endtask

  initial begin
    int cyc;
    int runs;
    int bad;
    logic [15:0] offlog;
    logic [127:0] vd;
    logic [127:0] vd_after;
    logic err;
    logic vv_after;
    int vv_seen;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 128'(req_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_run", 128'(alu_run), 128'd0);
    chk("rst_vd", vd_out, 128'd0);
    chk("rst_ctrs", 128'({alu_byte_i, alu_in_reg_offset, alu_opcode, vd_valid, err_illegal}), 128'd0);

    // 1: vadd sew8 vl16, all bytes 1+1
    vs1 = {16{8'h01}}; vs2 = {16{8'h01}};
    run_op(OP_ADD, 3'd0, 17'd16, 128'd0, 1'b0, cyc, runs, offlog, vd, err, bad, vv_after, vd_after);
    chk("t1_cyc", 128'(cyc), 128'd5);
    chk("t1_runs", 128'(runs), 128'd4);
    chk("t1_vd", vd, {16{8'h02}});
    chk("t1_err", 128'(err), 128'd0);
    chk("t1_pulse", 128'(vv_after), 128'd0);
    chk("t1_hold", vd_after, {16{8'h02}});

    // 2: vadd sew32 vl4, 0xFFFFFFFF + 1 carries through all four chunks
    vs2 = {4{32'hFFFF_FFFF}}; vs1 = {4{32'h0000_0001}};
    run_op(OP_ADD, 3'd2, 17'd4, {16{8'h55}}, 1'b0, cyc, runs, offlog, vd, err, bad, vv_after, vd_after);
    chk("t2_cyc", 128'(cyc), 128'd5);
    chk("t2_offs", 128'(offlog), 128'h0123);
    chk("t2_vd", vd, 128'd0);

    // 3: vand sew8 vl5, tail keeps 0xAA; req_valid held throughout
    vs2 = {16{8'h0F}}; vs1 = {16{8'hFF}};
    run_op(OP_AND, 3'd0, 17'd5, {16{8'hAA}}, 1'b1, cyc, runs, offlog, vd, err, bad, vv_after, vd_after);
    chk("t3_cyc", 128'(cyc), 128'd3);
    chk("t3_runs", 128'(runs), 128'd2);
    chk("t3_vd", vd, 128'hAAAAAAAAAAAAAAAAAAAAAA0F0F0F0F0F);
    chk("t3_busy", 128'(bad), 128'd0);
    chk("t3_opcode", 128'(alu_opcode), 128'(OP_AND));
    chk("t3_no_reaccept", 128'({busy, alu_run}), 128'd0);

    // 4a: vl=0 completes immediately with vd_old
    run_op(OP_ADD, 3'd0, 17'd0, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0,
           cyc, runs, offlog, vd, err, bad, vv_after, vd_after);
    chk("t4a_cyc", 128'(cyc), 128'd1);
    chk("t4a_runs", 128'(runs), 128'd0);
    chk("t4a_vd", vd, 128'h0123456789ABCDEF_FEDCBA9876543210);
    chk("t4a_err", 128'(err), 128'd0);

    // 4b: vl=200 clamps to 16 elements at sew8
    vs2 = {16{8'h01}}; vs1 = {16{8'h10}};
    run_op(OP_ADD, 3'd0, 17'd200, 128'd0, 1'b0, cyc, runs, offlog, vd, err, bad, vv_after, vd_after);
    chk("t4b_runs", 128'(runs), 128'd4);
    chk("t4b_vd", vd, {16{8'h11}});

    // 5a: illegal opcode aborts in the first RUN cycle
    run_op(OP_BAD, 3'd0, 17'd16, {8{16'hBEEF}}, 1'b0, cyc, runs, offlog, vd, err, bad, vv_after, vd_after);
    chk("t5a_err", 128'(err), 128'd1);
    chk("t5a_vd", vd, {8{16'hBEEF}});
    chk("t5a_cyc", 128'(cyc), 128'd2);

    // 5b: vsew=4 rejected with no RUN cycles
    run_op(OP_ADD, 3'd4, 17'd8, {4{32'hCAFE_F00D}}, 1'b0, cyc, runs, offlog, vd, err, bad, vv_after, vd_after);
    chk("t5b_err", 128'(err), 128'd1);
    chk("t5b_runs", 128'(runs), 128'd0);
    chk("t5b_vd", vd, {4{32'hCAFE_F00D}});

    // 6: sew64 op interrupted by reset at RUN cycle 3
    vs2 = {2{64'h1}}; vs1 = {2{64'h2}};
    req_opcode = OP_ADD; req_vsew = 3'd3; req_vl = 17'd2; req_vd_old = {16{8'h77}};
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (vd_valid) vv_seen++;
    end
    chk("t6_running", 128'({alu_run, alu_in_reg_offset}), 128'h12);
    resetn = 1'b0;
    @(negedge clk);
    chk("t6_rst_state", 128'({req_ready, busy, alu_run, vd_valid, err_illegal}), 128'b10000);
    chk("t6_rst_vd", vd_out, 128'd0);
    chk("t6_rst_ctrs", 128'({alu_byte_i, alu_in_reg_offset, alu_vsew}), 128'd0);
    resetn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (vd_valid) vv_seen++;
    end
    chk("t6_no_valid", 128'(vv_seen), 128'd0);
    vs2 = {16{8'h01}}; vs1 = {16{8'h02}};
    run_op(OP_ADD, 3'd0, 17'd16, 128'd0, 1'b0, cyc, runs, offlog, vd, err, bad, vv_after, vd_after);
    chk("t6_after_cyc", 128'(cyc), 128'd5);
    chk("t6_after_vd", vd, {16{8'h03}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
